// File: rtl/imul_iter_ctrl.sv
// imul_iter_ctrl: iterative shift-add integer multiplier with val/rdy streams.
// A three-state control FSM (IDLE/CALC/DONE) sequences operand, result and
// counter registers. Each CALC cycle performs one partial-product step.
// The result is the low p_nbits of a*b, which is correct for both signed and
// unsigned operands.
// Optional feature: define IMUL_EARLY_EXIT_EN to leave CALC as soon as the
// remaining multiplier bits are all zero. Products are the same either way;
// only latency changes.
module imul_iter_ctrl #(
  parameter int p_nbits = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   istream_val,
  output logic                   istream_rdy,
  input  logic [2*p_nbits-1:0]   istream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy,
  output logic [p_nbits-1:0]     ostream_msg
);

  localparam int CW = $clog2(p_nbits);
  localparam logic [CW-1:0] LastCount = CW'(p_nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [p_nbits-1:0] a_q, a_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] result_q, result_d;
  logic [CW-1:0]      count_q, count_d;
  logic [p_nbits-1:0] b_shifted;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign b_shifted = b_q >> 1;

  // Next-state and datapath update: load in IDLE, one shift-add step per CALC cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (istream_val && istream_rdy) begin
          a_d      = istream_msg[2*p_nbits-1:p_nbits];
          b_d      = istream_msg[p_nbits-1:0];
          result_d = '0;
          count_d  = '0;
          state_d  = CALC;
`ifdef IMUL_EARLY_EXIT_EN
          // A zero multiplier needs no steps at all.
          if (istream_msg[p_nbits-1:0] == '0) begin
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (b_q[0]) begin
          result_d = result_q + a_q;
        end
        a_d     = a_q << 1;
        b_d     = b_shifted;
        count_d = count_q + CW'(1);
        if (count_q == LastCount) begin
          state_d = DONE;
        end
`ifdef IMUL_EARLY_EXIT_EN
        // No set bits remain, so further steps could not change the result.
        if (b_shifted == '0) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (ostream_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stream outputs decoded from the state register only (plus reset gating).
  always_comb begin
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    ostream_msg = '0;
    if (state_q == IDLE && !rst) begin
      istream_rdy = 1'b1;
    end
    if (state_q == DONE) begin
      ostream_val = 1'b1;
      ostream_msg = result_q;
    end
  end

endmodule

// File: tb/tb_imul_iter_ctrl.sv
// tb_imul_iter_ctrl: directed scoreboard bench for imul_iter_ctrl.
// Expected products and latencies are queued when operands are issued and
// compared when the unit presents its result. IMUL_EARLY_EXIT_EN selects the
// matching latency model.
module tb_imul_iter_ctrl;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           istreamVal;
  logic           istreamRdy;
  logic [2*N-1:0] istreamMsg;
  logic           ostreamVal;
  logic           ostreamRdy;
  logic [N-1:0]   ostreamMsg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] prod;
    int           lat;
  } exp_t;

  exp_t sbQ[$];

  imul_iter_ctrl #(.p_nbits(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .istream_val (istreamVal),
    .istream_rdy (istreamRdy),
    .istream_msg (istreamMsg),
    .ostream_val (ostreamVal),
    .ostream_rdy (ostreamRdy),
    .ostream_msg (ostreamMsg)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Edges from the accept edge until ostream_val is first seen high.
  function automatic int modelLatency(input logic [N-1:0] b);
`ifdef IMUL_EARLY_EXIT_EN
    int hi;
    hi = -1;
    for (int i = 0; i < N; i++) begin
      if (b[i]) hi = i;
    end
    return hi + 1;
`else
    return N;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the unit to be ready, issues one operand pair and queues the expected result.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    int guard;
    logic [2*N-1:0] full;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!istreamRdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rdyBeforeIssue", {63'd0, istreamRdy}, 64'd1);
    istreamVal = 1'b1;
    istreamMsg = {a, b};
    full = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    e.prod = full[N-1:0];
    e.lat  = modelLatency(b);
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    istreamVal = 1'b0;
  endtask

  // Waits for the product, checks latency and value, optionally applies backpressure.
  task automatic waitProduct(input string tag, input int preK, input int holdCycles);
    int k;
    int depth;
    bit rdyLow;
    bit stable;
    logic [N-1:0] held;
    exp_t e;
    k = preK;
    rdyLow = 1'b1;
    stable = 1'b1;
    ostreamRdy = (holdCycles == 0);
    while (!ostreamVal && k < 200) begin
      if (istreamRdy) rdyLow = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput({tag, ".valid"}, {63'd0, ostreamVal}, 64'd1);
    depth = sbQ.size();
    checkOutput({tag, ".sbDepth"}, 64'(depth), 64'd1);
    if (depth > 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, ".latency"}, 64'(k), 64'(e.lat));
      checkOutput({tag, ".product"}, {32'd0, ostreamMsg}, {32'd0, e.prod});
    end
    checkOutput({tag, ".inRdyLowBusy"}, {63'd0, rdyLow}, 64'd1);
    if (holdCycles > 0) begin
      held = ostreamMsg;
      repeat (holdCycles) begin
        @(posedge clk);
        #1;
        if (ostreamMsg !== held || !ostreamVal || istreamRdy) stable = 1'b0;
      end
      checkOutput({tag, ".heldStable"}, {63'd0, stable}, 64'd1);
      ostreamRdy = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ".rdyAfter"}, {63'd0, istreamRdy}, 64'd1);
    checkOutput({tag, ".valAfter"}, {63'd0, ostreamVal}, 64'd0);
  endtask

  // Safety net in case something escapes the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of operations.
  initial begin
    bit stale;
    rst        = 1'b1;
    istreamVal = 1'b0;
    istreamMsg = '0;
    ostreamRdy = 1'b1;
    #3;
    checkOutput("reset.inRdy",  {63'd0, istreamRdy}, 64'd0);
    checkOutput("reset.outVal", {63'd0, ostreamVal}, 64'd0);
    checkOutput("reset.outMsg", {32'd0, ostreamMsg}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postReset.inRdy", {63'd0, istreamRdy}, 64'd1);

    // Basic product, with istream_val held while busy to show it is ignored.
    applyStimulus(32'd3, 32'd4);
    istreamVal = 1'b1;
    istreamMsg = {32'd5, 32'd5};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    istreamVal = 1'b0;
    waitProduct("basic3x4", 2, 0);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitProduct("wrap", 0, 0);

    applyStimulus(32'hFFFF_FFFD, 32'd5);
    waitProduct("signed", 0, 0);

    applyStimulus(32'd7, 32'd0);
    waitProduct("zeroB", 0, 0);

    applyStimulus(32'd6, 32'd7);
    waitProduct("backpressure", 0, 5);

    // Reset in the middle of a 9x9; the product must never appear.
    applyStimulus(32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midReset.outVal", {63'd0, ostreamVal}, 64'd0);
    checkOutput("midReset.inRdy",  {63'd0, istreamRdy}, 64'd0);
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ostreamVal) stale = 1'b1;
    end
    checkOutput("midReset.noStale", {63'd0, stale}, 64'd0);
    applyStimulus(32'd2, 32'd2);
    waitProduct("afterReset2x2", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
